// File: rtl/mix_columns_engine_pkg.sv
// Shared types, GF(2^8) helpers and FSM encoding for the MixColumns engine.
// Byte s0 of each column sits in the MSB; column 0 is the top 32 bits of the state.
package mix_columns_engine_pkg;

  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } fsm_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // The inverse coefficients share the x*2, x*4, x*8 chain.
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  function automatic aes_col_t get_col(input aes_state_t s, input int unsigned c);
    return s[127 - 32 * c -: 32];
  endfunction

  function automatic aes_state_t set_col(input aes_state_t s, input int unsigned c,
                                         input aes_col_t v);
    aes_state_t r;
    r = s;
    r[127 - 32 * c -: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Upstream/downstream valid-ready bundle for the MixColumns engine.
interface mix_columns_engine_if;
  import mix_columns_engine_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/mix_columns_engine_mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on a single 32-bit column.
module mix_column_unit
  import mix_columns_engine_pkg::*;
(
  input  aes_col_t col,
  input  logic     inv,
  output aes_col_t result
);

  logic [7:0] s0, s1, s2, s3;
  aes_col_t   fwd, bwd;

  assign {s0, s1, s2, s3} = col;

  assign fwd = {
    gf_mul2(s0) ^ gf_mul3(s1) ^ s2          ^ s3,
    s0          ^ gf_mul2(s1) ^ gf_mul3(s2) ^ s3,
    s0          ^ s1          ^ gf_mul2(s2) ^ gf_mul3(s3),
    gf_mul3(s0) ^ s1          ^ s2          ^ gf_mul2(s3)
  };

  assign bwd = {
    gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3),
    gf_mul9(s0) ^ gf_mule(s1) ^ gf_mulb(s2) ^ gf_muld(s3),
    gf_muld(s0) ^ gf_mul9(s1) ^ gf_mule(s2) ^ gf_mulb(s3),
    gf_mulb(s0) ^ gf_muld(s1) ^ gf_mul9(s2) ^ gf_mule(s3)
  };

  assign result = inv ? bwd : fwd;

endmodule

// File: rtl/mix_columns_engine.sv
// Multi-cycle MixColumns/InvMixColumns engine; COLS_PER_CYCLE columns per clock,
// result available NCYC cycles after acceptance, one transaction per NCYC+1 cycles.
module mix_columns_engine
  import mix_columns_engine_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst,
  mix_columns_engine_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned NCYC = (COLS_PER_CYCLE == 0) ? 4 : 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  CntLast = 2'(NCYC - 1);

  fsm_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  aes_state_t src_q, src_d;
  aes_state_t res_q, res_d;
  logic       inv_q, inv_d;
  logic       in_ready;
  logic       accept;

  aes_col_t unit_in  [COLS_PER_CYCLE];
  aes_col_t unit_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gen_unit
    assign unit_in[g] = get_col(src_q, 32'(cnt_q) * COLS_PER_CYCLE + g);

    mix_column_unit u_unit (
      .col    (unit_in[g]),
      .inv    (inv_q),
      .result (unit_out[g])
    );
  end

  // A finishing result may hand off and accept a new job in the same cycle.
  assign in_ready = !rst && ((state_q == StIdle) || (state_q == StDone && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_state = res_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    inv_d   = inv_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          src_d   = bus.in_state;
          inv_d   = bus.in_inv;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
          res_d = set_col(res_d, 32'(cnt_q) * COLS_PER_CYCLE + g, unit_out[g]);
        end
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDone: begin
        if (accept) begin
          src_d   = bus.in_state;
          inv_d   = bus.in_inv;
          cnt_d   = '0;
          state_d = StBusy;
        end else if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Sequential, parametrised successor to the single-column combinational MixColumns.
- Accepts a full 128-bit AES state over a valid/ready handshake and applies MixColumns (encrypt) or InvMixColumns (decrypt), selected per transaction.
- Processes COLS_PER_CYCLE columns per clock to trade area for latency.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the round datapath.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous and active-high
in_valid  input  1  input transaction valid
in_ready  output  1  engine can accept a transaction this cycle
in_state  input  128  AES state; column c = in_state[127-32c -: 32], byte s0 in MSB of each column
in_inv  input  1  0 = forward MixColumns, 1 = InvMixColumns; sampled with in_state
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_state  output  128  transformed state, same column/byte ordering as in_state

Behaviour:
- One clock; reset is synchronous and active-high. rst has priority over every other event.
- Reset values: out_valid=0, out_state=0, in_ready=0 during the cycle rst is high, FSM=IDLE, column counter=0.
- Constants: NCYC = 4/COLS_PER_CYCLE (4, 2 or 1).
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_state and in_inv, clear counter, go to BUSY.
  - BUSY: each cycle, transform columns [cnt*C .. cnt*C+C-1] from the latched state into a result register, then cnt += 1. On the cycle cnt==NCYC-1, go to DONE; cnt wraps to 0.
  - DONE: out_valid=1, out_state stable. On out_ready, go to IDLE.
  - Back-to-back: in_ready is also 1 in DONE when out_ready=1. A simultaneous accept loads the new transaction and goes directly to BUSY. This gives one transaction per NCYC+1 cycles.
- Latency: a transaction accepted at edge T has out_valid=1 from edge T+NCYC.
- Backpressure: while out_valid && !out_ready, out_state and out_valid hold and in_ready=0.
- Changes to in_state or in_inv after acceptance have no effect.
- Forward matrix rows: [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2].
- Inverse matrix rows: [e b d 9], [9 e b d], [d 9 e b], [b d 9 e].
- GF(2^8) arithmetic:
  - xtime(x) = {x[6:0],0} ^ (x[7] ? 0x1b : 0).
  - Multiplication by 9, b, d, e is built from xtime chains and XOR only.
  - All bytes are 8-bit; no carries.
- in_valid while in_ready=0: ignored; the upstream holds it.
- rst in BUSY or DONE: the transaction is discarded with no output and the FSM returns to IDLE the next cycle.

Decomposition:
- aes_pkg holds:
  - functions xtime, gf_mul2/3/9/b/d/e;
  - typedef aes_col_t (logic[31:0]) and aes_state_t (logic[127:0]);
  - the column slice helper;
  - FSM enum {IDLE, BUSY, DONE}.
- One sub-module mix_column_unit:
  - combinational, one 32-bit column in and out, plus an inv select;
  - instantiated COLS_PER_CYCLE times in a generate loop.
- The top level owns the FSM, counter, latched input and result register.

Test Plan:
- COLS_PER_CYCLE=1, inv=0:
  - in_state = db135345 f20a225c 01010101 c6c6c6c6 -> out_state = 8e4da1bc 9fdc589d 01010101 c6c6c6c6.
  - out_valid exactly 4 cycles after accept.
- COLS_PER_CYCLE=4, inv=1:
  - in_state = 8e4da1bc 9fdc589d 01010101 c6c6c6c6 -> db135345 f20a225c 01010101 c6c6c6c6.
  - out_valid 1 cycle after accept.
- COLS_PER_CYCLE=2, inv=0:
  - in_state = d4d4d4d5 2d26314c 00000000 ffffffff -> d5d5d7d6 4d7ebdf8 00000000 ffffffff.
  - Then the same output fed back with inv=1 returns the original state.
- Backpressure: hold out_ready=0 for 5 cycles -> out_state/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> simultaneous accept, next result NCYC cycles later.
- Reset mid-operation: assert rst during BUSY cycle 2 -> the next cycle has out_valid=0, in_ready=1, and no stale result ever appears.
- Random: 1000 transactions with random in_inv and random valid/ready stalls, checked against a scoreboard reference model for all three COLS_PER_CYCLE values.
